// File: rtl/traffic_light_monitor.sv
// Passive checker for a two-street traffic-light controller. It samples the light
// codes and traffic sensors every rising edge, tracks the expected phase, and reports
// illegal codes, conflicting greens, bad per-street sequences, ignored sensors and
// wrong yellow dwell. It never drives the controller.
//
// Ports:
//   CLK        clock, rising edge
//   RESET      synchronous, active-high reset
//   LA, LB     street A/B light: 00 green, 01 yellow, 10 red, 11 illegal
//   TA, TB     street A/B traffic sensor (1 = traffic present)
//   state      tracked phase: 0 SYNC, 1 A_GREEN, 2 A_YELLOW, 3 B_GREEN, 4 B_YELLOW
//   err        sticky error flag
//   err_code   code of the first error (0 none, 1 ILLEGAL, 2 CONFLICT, 3 SEQ, 4 RESP, 5 DWELL)
//   err_pulse  high for one cycle after each erroneous sample
//   err_count  number of erroneous samples, saturating
//   phase_cnt  completed B_YELLOW -> A_GREEN cycles, wrapping
module traffic_light_monitor #(
  parameter int unsigned YELLOW_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       LA,
  input  logic [1:0]       LB,
  input  logic             TA,
  input  logic             TB,
  output logic [2:0]       state,
  output logic             err,
  output logic [2:0]       err_code,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] phase_cnt
);

  typedef enum logic [2:0] {
    StSync    = 3'd0,
    StAGreen  = 3'd1,
    StAYellow = 3'd2,
    StBGreen  = 3'd3,
    StBYellow = 3'd4
  } state_e;

  localparam logic [1:0] LGreen  = 2'b00;
  localparam logic [1:0] LYellow = 2'b01;
  localparam logic [1:0] LRed    = 2'b10;
  localparam logic [1:0] LIll    = 2'b11;

  localparam logic [2:0] CodeNone     = 3'd0;
  localparam logic [2:0] CodeIllegal  = 3'd1;
  localparam logic [2:0] CodeConflict = 3'd2;
  localparam logic [2:0] CodeSeq      = 3'd3;
  localparam logic [2:0] CodeResp     = 3'd4;
  localparam logic [2:0] CodeDwell    = 3'd5;

  localparam int unsigned YW = $clog2(YELLOW_CYCLES + 1);
  localparam logic [YW-1:0] YLimit = YW'(YELLOW_CYCLES);

  state_e           state_q, state_d;
  logic [YW-1:0]    y_cnt_q, y_cnt_d;
  logic             ta_q, tb_q;
  logic             err_q;
  logic [2:0]       err_code_q;
  logic             err_pulse_q;
  logic [CNT_W-1:0] err_count_q;
  logic [CNT_W-1:0] phase_cnt_q;

  logic [2:0]       code;
  logic             phase_inc;
  logic             is_a;
  logic [1:0]       own, oth;
  logic             own_t;

  // The A and B phases share one set of rules: "own" is the street currently holding
  // right of way, "oth" is the street that must stay red.
  always_comb begin
    state_d   = state_q;
    y_cnt_d   = y_cnt_q;
    code      = CodeNone;
    phase_inc = 1'b0;
    is_a      = (state_q == StAGreen) || (state_q == StAYellow);
    own       = is_a ? LA : LB;
    oth       = is_a ? LB : LA;
    own_t     = is_a ? ta_q : tb_q;

    if (LA == LIll || LB == LIll) begin
      code = CodeIllegal;
    end else if (LA != LRed && LB != LRed) begin
      code = CodeConflict;
    end else begin
      unique case (state_q)
        StSync: begin
          if (LA == LGreen && LB == LRed)      state_d = StAGreen;
          else if (LB == LGreen && LA == LRed) state_d = StBGreen;
        end
        StAGreen, StBGreen: begin
          if (oth != LRed) begin
            code = CodeSeq;
          end else if (own == LGreen) begin
            if (!own_t) code = CodeResp;
          end else if (own == LYellow) begin
            state_d = is_a ? StAYellow : StBYellow;
            y_cnt_d = YW'(1);
            if (own_t) code = CodeResp;
          end else begin
            code = CodeSeq;
          end
        end
        StAYellow, StBYellow: begin
          if (own == LYellow && oth == LRed) begin
            if (y_cnt_q == YLimit) code = CodeDwell;
            else                   y_cnt_d = y_cnt_q + YW'(1);
          end else if (own == LRed && oth == LGreen) begin
            state_d   = is_a ? StBGreen : StAGreen;
            phase_inc = !is_a;
            if (y_cnt_q < YLimit) code = CodeDwell;
          end else begin
            code = CodeSeq;
          end
        end
        default: state_d = StSync;
      endcase
    end

    // Any error drops back to SYNC; a cycle that ends in error does not count as completed.
    if (code != CodeNone) begin
      state_d   = StSync;
      y_cnt_d   = '0;
      phase_inc = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StSync;
      y_cnt_q     <= '0;
      ta_q        <= 1'b0;
      tb_q        <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= CodeNone;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      phase_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      y_cnt_q     <= y_cnt_d;
      ta_q        <= TA;
      tb_q        <= TB;
      err_pulse_q <= (code != CodeNone);
      if (code != CodeNone) begin
        if (err_count_q != {CNT_W{1'b1}}) err_count_q <= err_count_q + CNT_W'(1);
        if (!err_q) begin
          err_q      <= 1'b1;
          err_code_q <= code;
        end
      end
      if (phase_inc) phase_cnt_q <= phase_cnt_q + CNT_W'(1);
    end
  end

  assign state     = state_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign phase_cnt = phase_cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: one instance with YELLOW_CYCLES=1 and one
// with YELLOW_CYCLES=3, sharing clock and reset but with independent light inputs.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] la1 = 2'b10, lb1 = 2'b10;
  logic       ta1 = 1'b0, tb1 = 1'b0;
  logic [1:0] la3 = 2'b10, lb3 = 2'b10;
  logic       ta3 = 1'b0, tb3 = 1'b0;

  logic [2:0] st1, code1, st3, code3;
  logic       err1, pulse1, err3, pulse3;
  logic [7:0] ecnt1, pcnt1, ecnt3, pcnt3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  traffic_light_monitor #(.YELLOW_CYCLES(1), .CNT_W(8)) dut1 (
    .CLK(clk), .RESET(rst), .LA(la1), .LB(lb1), .TA(ta1), .TB(tb1),
    .state(st1), .err(err1), .err_code(code1), .err_pulse(pulse1),
    .err_count(ecnt1), .phase_cnt(pcnt1)
  );

  traffic_light_monitor #(.YELLOW_CYCLES(3), .CNT_W(8)) dut3 (
    .CLK(clk), .RESET(rst), .LA(la3), .LB(lb3), .TA(ta3), .TB(tb3),
    .state(st3), .err(err3), .err_code(code3), .err_pulse(pulse3),
    .err_count(ecnt3), .phase_cnt(pcnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic ta, input logic tb);
    @(negedge clk);
    rst = 1'b0; la1 = a; lb1 = b; ta1 = ta; tb1 = tb;
    @(posedge clk);
    #1;
  endtask

  task automatic step3(input logic [1:0] a, input logic [1:0] b, input logic ta, input logic tb);
    @(negedge clk);
    rst = 1'b0; la3 = a; lb3 = b; ta3 = ta; tb3 = tb;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One full A -> B -> A cycle, entered and left in A_GREEN with previous TA=0.
  task automatic loop_ab();
    step(2'b01, 2'b10, 1'b0, 1'b1);
    step(2'b10, 2'b00, 1'b0, 1'b1);
    step(2'b10, 2'b00, 1'b0, 1'b0);
    step(2'b10, 2'b01, 1'b0, 1'b0);
    step(2'b00, 2'b10, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset();
    chk("rst_state", st1, 0);
    chk("rst_err", err1, 0);
    chk("rst_code", code1, 0);
    chk("rst_pulse", pulse1, 0);
    chk("rst_ecnt", ecnt1, 0);
    chk("rst_pcnt", pcnt1, 0);

    // SYNC -> A_GREEN, hold with traffic, then yield.
    step(2'b00, 2'b10, 1'b1, 1'b0); chk("sync_to_ag", st1, 1);
    step(2'b00, 2'b10, 1'b1, 1'b0); chk("ag_hold1", st1, 1);
    step(2'b00, 2'b10, 1'b1, 1'b0); chk("ag_hold2", st1, 1);
    step(2'b00, 2'b10, 1'b0, 1'b0); chk("ag_hold3", st1, 1);
    step(2'b01, 2'b10, 1'b0, 1'b1); chk("ag_to_ay", st1, 2);
    step(2'b10, 2'b00, 1'b0, 1'b1); chk("ay_to_bg", st1, 3);
    chk("handoff_noerr", err1, 0);
    step(2'b10, 2'b00, 1'b0, 1'b0); chk("bg_hold", st1, 3);
    step(2'b10, 2'b01, 1'b0, 1'b0); chk("bg_to_by", st1, 4);
    step(2'b00, 2'b10, 1'b0, 1'b0); chk("by_to_ag", st1, 1);
    chk("pcnt_one", pcnt1, 1);
    chk("loop_noerr", err1, 0);

    for (int i = 0; i < 254; i++) loop_ab();
    chk("pcnt_255", pcnt1, 255);
    loop_ab();
    chk("pcnt_wrap", pcnt1, 0);
    chk("wrap_noerr", err1, 0);
    chk("wrap_state", st1, 1);

    // Conflict in A_GREEN, then an illegal code must not overwrite the first code.
    step(2'b00, 2'b00, 1'b0, 1'b0);
    chk("conf_pulse", pulse1, 1);
    chk("conf_code", code1, 2);
    chk("conf_state", st1, 0);
    chk("conf_ecnt", ecnt1, 1);
    step(2'b11, 2'b10, 1'b0, 1'b0);
    chk("ill_code_frozen", code1, 2);
    chk("ill_ecnt", ecnt1, 2);
    chk("ill_pulse", pulse1, 1);
    step(2'b10, 2'b10, 1'b0, 1'b0);
    chk("clean_pulse", pulse1, 0);
    chk("clean_ecnt", ecnt1, 2);
    chk("sticky_err", err1, 1);

    // Yellow held one sample too long.
    do_reset();
    step(2'b00, 2'b10, 1'b0, 1'b0);
    step(2'b01, 2'b10, 1'b0, 1'b0); chk("dw_ay", st1, 2);
    step(2'b01, 2'b10, 1'b0, 1'b0);
    chk("dwell_code", code1, 5);
    chk("dwell_state", st1, 0);

    // Yellow requested while traffic was still present.
    do_reset();
    step(2'b00, 2'b10, 1'b1, 1'b0);
    step(2'b01, 2'b10, 1'b0, 1'b0);
    chk("resp_early_code", code1, 4);

    // Green held with no traffic.
    do_reset();
    step(2'b00, 2'b10, 1'b0, 1'b0);
    step(2'b00, 2'b10, 1'b0, 1'b0);
    chk("resp_hold_code", code1, 4);

    // A_GREEN going straight to red.
    do_reset();
    step(2'b00, 2'b10, 1'b0, 1'b0);
    step(2'b10, 2'b10, 1'b0, 1'b0);
    chk("seq_code", code1, 3);

    // Resync into B_YELLOW with err set, then reset there.
    step(2'b10, 2'b00, 1'b0, 1'b0); chk("resync_bg", st1, 3);
    step(2'b10, 2'b01, 1'b0, 1'b0); chk("resync_by", st1, 4);
    chk("by_err_set", err1, 1);
    do_reset();
    chk("mid_rst_state", st1, 0);
    chk("mid_rst_err", err1, 0);
    chk("mid_rst_code", code1, 0);
    chk("mid_rst_pulse", pulse1, 0);
    chk("mid_rst_ecnt", ecnt1, 0);
    chk("mid_rst_pcnt", pcnt1, 0);

    // YELLOW_CYCLES=3: leaving yellow after 2 samples is a dwell error.
    la1 = 2'b10; lb1 = 2'b10;
    step3(2'b00, 2'b10, 1'b0, 1'b0); chk("y3_ag", st3, 1);
    step3(2'b01, 2'b10, 1'b0, 1'b0); chk("y3_ay1", st3, 2);
    step3(2'b01, 2'b10, 1'b0, 1'b0); chk("y3_ay2", st3, 2);
    step3(2'b10, 2'b00, 1'b0, 1'b0);
    chk("y3_short_code", code3, 5);
    chk("y3_short_state", st3, 0);

    // YELLOW_CYCLES=3: exactly three yellow samples is legal.
    do_reset();
    step3(2'b00, 2'b10, 1'b0, 1'b0);
    step3(2'b01, 2'b10, 1'b0, 1'b0);
    step3(2'b01, 2'b10, 1'b0, 1'b0);
    step3(2'b01, 2'b10, 1'b0, 1'b0); chk("y3_ay3", st3, 2);
    step3(2'b10, 2'b00, 1'b0, 1'b0);
    chk("y3_ok_state", st3, 3);
    chk("y3_ok_err", err3, 0);
    chk("idle_dut1_err", err1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
